// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision FP constants, operand class and exception flag types
package fp_pkg;
  localparam int EXP_WIDTH = 8;
  localparam int MAN_WIDTH = 23;
  localparam int BIAS = 127;
  typedef enum logic [1:0] {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN} fp_class_t;
  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
  } fp_flags_t;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational IEEE operand classifier (subnormals read as zero)
//   x   in  packed IEEE operand
//   cls out operand class
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH = fp_pkg::EXP_WIDTH,
  parameter int MAN_WIDTH = fp_pkg::MAN_WIDTH
) (
  input  logic [EXP_WIDTH+MAN_WIDTH:0] x,
  output fp_class_t                    cls
);
  logic [EXP_WIDTH-1:0] ex;
  logic [MAN_WIDTH-1:0] fr;
  assign ex = x[EXP_WIDTH+MAN_WIDTH-1:MAN_WIDTH];
  assign fr = x[MAN_WIDTH-1:0];
  assign cls = ~|ex ? FP_ZERO : ~&ex ? FP_NORMAL : |fr ? FP_NAN : FP_INF;
endmodule

// File: rtl/fp_div_pack.sv
// fp_div_pack: two-stage FP divide back end: exponent, special cases, saturation, packing
//   in_valid/in_ready    accept a, b, m3, decrement_exponent
//   out_valid/out_ready  deliver result and one-hot flags
//   rst_n                asynchronous active-low reset
module fp_div_pack
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH = fp_pkg::EXP_WIDTH,
  parameter int MAN_WIDTH = fp_pkg::MAN_WIDTH,
  parameter int BIAS = fp_pkg::BIAS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] a,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] b,
  input  logic [MAN_WIDTH-1:0]         m3,
  input  logic                         decrement_exponent,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0] result,
  output logic                         flag_invalid,
  output logic                         flag_div_by_zero,
  output logic                         flag_overflow,
  output logic                         flag_underflow
);
  localparam int W = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int EW2 = EXP_WIDTH + 2;
  localparam logic signed [EW2-1:0] EMAX = EW2'((2 ** EXP_WIDTH) - 1);
  fp_class_t ca, cb, ca1, cb1;
  logic v1, v2, adv1, adv2, s1;
  logic signed [EW2-1:0] e_nx, e1;
  logic [MAN_WIDTH-1:0] m1;
  logic [W-1:0] res_nx, inf_w, zero_w, norm_w, qnan;
  fp_flags_t flg_nx, flg;
  logic an, bn, ai, bi, az, bz, anr, bnr, inv, dbz, inf3, zer, nn, ov, uf;
  fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_cls_a (.x(a), .cls(ca));
  fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_cls_b (.x(b), .cls(cb));
  assign adv2 = ~v2 | out_ready;
  assign adv1 = ~v1 | adv2;
  assign in_ready = adv1;
  // EW2 bits holds the full range of ea-eb+BIAS-1 without wrapping
  assign e_nx = EW2'({2'b00, a[W-2:MAN_WIDTH]}) - EW2'({2'b00, b[W-2:MAN_WIDTH]})
              + EW2'(BIAS) - EW2'(decrement_exponent);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      ca1 <= FP_ZERO;
      cb1 <= FP_ZERO;
      s1  <= 1'b0;
      e1  <= '0;
      m1  <= '0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv1 && in_valid) begin
        ca1 <= ca;
        cb1 <= cb;
        s1  <= a[W-1] ^ b[W-1];
        e1  <= e_nx;
        m1  <= m3;
      end
    end
  end
  always_comb begin
    an  = ca1 == FP_NAN;
    bn  = cb1 == FP_NAN;
    ai  = ca1 == FP_INF;
    bi  = cb1 == FP_INF;
    az  = ca1 == FP_ZERO;
    bz  = cb1 == FP_ZERO;
    anr = ca1 == FP_NORMAL;
    bnr = cb1 == FP_NORMAL;
    inv  = an | bn | (az & bz) | (ai & bi);
    dbz  = anr & bz;
    inf3 = ai & (bz | bnr);
    zer  = (az & ~bz) | (~ai & bi);
    nn   = anr & bnr;
    ov   = e1 >= EMAX;
    uf   = e1 <= 0;
    qnan   = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH - 1){1'b0}}};
    inf_w  = {s1, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
    zero_w = {s1, {(W - 1){1'b0}}};
    norm_w = {s1, e1[EXP_WIDTH-1:0], m1};
    res_nx = inv ? qnan : (dbz | inf3) ? inf_w : zer ? zero_w :
             ov ? inf_w : uf ? zero_w : norm_w;
    flg_nx = {inv, dbz, nn & ov, nn & ~ov & uf};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      result <= '0;
      flg    <= '0;
    end else begin
      if (adv2) v2 <= v1;
      if (adv2 && v1) begin
        result <= res_nx;
        flg    <= flg_nx;
      end
    end
  end
  assign out_valid        = v2;
  assign flag_invalid     = flg.invalid;
  assign flag_div_by_zero = flg.div_by_zero;
  assign flag_overflow    = flg.overflow;
  assign flag_underflow   = flg.underflow;
endmodule
